vram_port_arbiter: RTL and testbench

Shares the single read/write port of the video memory (frame buffer plus glyph library) between two requesters. The VGA controller's frame-buffer fetch is one; the CPU data bus is the other.
- VGA reads have absolute priority and a fixed latency, so scan-out never tears.
- CPU reads and writes use a req/ack handshake and are slotted into idle cycles.
- Sits between the VGA controller, the CPU memory stage and the memory's port A.

---
 rtl/vram_pkg.sv | 25 ++
 rtl/vram_wait_counter.sv | 38 +++
 rtl/vram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM port arbiter slice.
// Optional glyph write protection is enabled with VRAM_ARB_VGA_PROTECT_EN.
package vram_pkg;

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_VGA    = 2'd1,
      TAG_CPU_RD = 2'd2,
      TAG_CPU_WR = 2'd3
   } tag_e;

   typedef enum logic {
      C_IDLE = 1'b0,
      C_BUSY = 1'b1
   } cpu_state_e;

   localparam logic [3:0]  GLYPH_REGION = 4'b0111;
   localparam logic [14:0] FB_OFFSET    = 15'h2000;

   // Top four address bits select the glyph library.
   function automatic logic is_glyph(input logic [3:0] hi);
      return hi == GLYPH_REGION;
   endfunction

endpackage

// File: rtl/vram_wait_counter.sv
// Saturating CPU wait counter with registered starvation flag.
module vram_wait_counter #(
   parameter int LIMIT = 31
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic inc_i,
   input  logic clr_i,
   output logic starve_o
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         starve_q, starve_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
      starve_d = (cnt_d >= W'(LIMIT));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q    <= '0;
         starve_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

   assign starve_o = starve_q;

endmodule

// File: rtl/vram_port_arbiter.sv
// VRAM port A arbiter: fixed-latency VGA reads, CPU req/ack in idle slots.
// Define VRAM_ARB_VGA_PROTECT_EN to block CPU writes to the glyph library.
module vram_port_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 31
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_starve,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
`ifdef VRAM_ARB_VGA_PROTECT_EN
   ,
   output logic              prot_err
`endif
);

   cpu_state_e        st_q, st_d;
   tag_e              tag1_q, tag1_d;
   tag_e              tag2_q;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic [DATA_W-1:0] vga_rdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic              cpu_elig;
   logic              cpu_issue;
   logic              wait_inc;
`ifdef VRAM_ARB_VGA_PROTECT_EN
   logic              prot_set;
   logic              prot_q;
`endif

   assign cpu_elig = (st_q == C_IDLE) && cpu_req;

   // Issue stage: VGA always wins the slot.
   always_comb begin
      tag1_d     = TAG_NONE;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      cpu_issue  = 1'b0;
`ifdef VRAM_ARB_VGA_PROTECT_EN
      prot_set   = 1'b0;
`endif
      priority case (1'b1)
         vga_req: begin
            tag1_d     = TAG_VGA;
            mem_en_d   = 1'b1;
            mem_addr_d = vga_addr;
         end
         cpu_elig: begin
            cpu_issue = 1'b1;
            if (cpu_we) begin
               tag1_d = TAG_CPU_WR;
`ifdef VRAM_ARB_VGA_PROTECT_EN
               if (is_glyph(cpu_addr[ADDR_W-1 -: 4])) begin
                  prot_set = 1'b1;
               end else begin
                  mem_en_d   = 1'b1;
                  mem_we_d   = 1'b1;
                  mem_addr_d = cpu_addr;
                  mem_din_d  = cpu_wdata;
               end
`else
               mem_en_d   = 1'b1;
               mem_we_d   = 1'b1;
               mem_addr_d = cpu_addr;
               mem_din_d  = cpu_wdata;
`endif
            end else begin
               tag1_d     = TAG_CPU_RD;
               mem_en_d   = 1'b1;
               mem_addr_d = cpu_addr;
            end
         end
         default: ;
      endcase
   end

   assign cpu_ack    = (tag2_q == TAG_CPU_RD) || (tag2_q == TAG_CPU_WR);
   assign vga_rvalid = (tag2_q == TAG_VGA);
   assign vga_rdata  = vga_rvalid ? mem_dout : vga_rdata_q;
   assign cpu_rdata  = (tag2_q == TAG_CPU_RD) ? mem_dout : cpu_rdata_q;

   // Busy until the CPU return slot fires, so req is ignored in the ack cycle.
   always_comb begin
      st_d = st_q;
      unique case (st_q)
         C_IDLE: if (cpu_issue) st_d = C_BUSY;
         C_BUSY: if (cpu_ack)   st_d = C_IDLE;
         default: st_d = C_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st_q        <= C_IDLE;
         tag1_q      <= TAG_NONE;
         tag2_q      <= TAG_NONE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         vga_rdata_q <= '0;
         cpu_rdata_q <= '0;
      end else begin
         st_q        <= st_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag1_q;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         vga_rdata_q <= vga_rdata;
         cpu_rdata_q <= cpu_rdata;
      end
   end

`ifdef VRAM_ARB_VGA_PROTECT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) prot_q <= 1'b0;
      else        prot_q <= prot_q | prot_set;
   end

   assign prot_err = prot_q;
`endif

   assign mem_en   = mem_en_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

   assign wait_inc = cpu_elig && !cpu_issue;

   vram_wait_counter #(
      .LIMIT(STARVE_LIMIT)
   ) u_wait (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .inc_i   (wait_inc),
      .clr_i   (cpu_issue),
      .starve_o(cpu_starve)
   );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: cycle model plus directed scenarios.
module tb_vram_port_arbiter;

   localparam int AW = 15;
   localparam int DW = 16;
   localparam int SL = 31;
   localparam int N  = 1024;
`ifdef VRAM_ARB_VGA_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          vga_req = 1'b0;
   logic [AW-1:0] vga_addr = '0;
   logic          vga_rvalid;
   logic [DW-1:0] vga_rdata;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_starve;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;
`ifdef VRAM_ARB_VGA_PROTECT_EN
   logic          prot_err;
`endif

   vram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .vga_req   (vga_req),
      .vga_addr  (vga_addr),
      .vga_rvalid(vga_rvalid),
      .vga_rdata (vga_rdata),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .cpu_starve(cpu_starve),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
`ifdef VRAM_ARB_VGA_PROTECT_EN
      ,
      .prot_err  (prot_err)
`endif
   );

   always #5 CLK = ~CLK;

   // Synchronous RAM; unwritten words read back as their own address.
   bit [DW-1:0] ram [1<<AW];
   bit          ram_wr [1<<AW];
   always @(posedge CLK) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]    <= mem_din;
            ram_wr[mem_addr] <= 1'b1;
         end
         mem_dout <= ram_wr[mem_addr] ? ram[mem_addr] : DW'(mem_addr);
      end
   end

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                  nm, cyc, act, exp);
      end
   endtask

   // Model state: expected outputs scheduled by cycle number.
   bit          e_en [N], e_we [N], e_vv [N], e_ack [N], e_ackrd [N], e_st [N];
   bit [AW-1:0] e_addr [N];
   bit [DW-1:0] e_din [N], e_vd [N], e_crd [N];
   bit [DW-1:0] mdl_ram [1<<AW];
   bit          mdl_wr [1<<AW];
   int          free_at = 0;
   int          wcnt = 0;
   int          prot_at = -1;
   bit [AW-1:0] last_addr = '0;
   bit [DW-1:0] last_din = '0;
   bit [DW-1:0] hv_vga = '0;
   bit [DW-1:0] hv_cpu = '0;

   function automatic bit [DW-1:0] mdl_rd(input bit [AW-1:0] a);
      return mdl_wr[a] ? mdl_ram[a] : DW'(a);
   endfunction

   always @(negedge CLK) begin : model
      int c, i, n1, n2, j;
      bit idle, iss;
      c  = cyc;
      i  = c % N;
      n1 = (c + 1) % N;
      n2 = (c + 2) % N;
      if (!RST_N) begin
         chk("rst_ctl", {vga_rvalid, cpu_ack, cpu_starve, mem_en, mem_we}, '0);
         chk("rst_data", {vga_rdata, cpu_rdata, mem_din, mem_addr}, '0);
`ifdef VRAM_ARB_VGA_PROTECT_EN
         chk("rst_prot", prot_err, '0);
`endif
         free_at = 0; wcnt = 0; prot_at = -1;
         last_addr = '0; last_din = '0; hv_vga = '0; hv_cpu = '0;
         for (int k = 1; k <= 2; k++) begin
            j = (c + k) % N;
            e_en[j] = 0; e_we[j] = 0; e_vv[j] = 0; e_ack[j] = 0;
            e_ackrd[j] = 0; e_st[j] = 0; e_addr[j] = '0; e_din[j] = '0;
         end
      end else begin
         if (e_vv[i])    hv_vga = e_vd[i];
         if (e_ackrd[i]) hv_cpu = e_crd[i];
         chk("vga_rvalid", vga_rvalid, e_vv[i]);
         chk("vga_rdata", vga_rdata, hv_vga);
         chk("cpu_ack", cpu_ack, e_ack[i]);
         chk("cpu_rdata", cpu_rdata, hv_cpu);
         chk("cpu_starve", cpu_starve, e_st[i]);
         chk("mem_en", mem_en, e_en[i]);
         chk("mem_we", mem_we, e_we[i]);
         chk("mem_addr", mem_addr, e_addr[i]);
         chk("mem_din", mem_din, e_din[i]);
`ifdef VRAM_ARB_VGA_PROTECT_EN
         chk("prot_err", prot_err, (prot_at >= 0) && (c >= prot_at));
`endif
         idle = (c >= free_at);
         iss  = 0;
         e_en[n1] = 0; e_we[n1] = 0;
         e_vv[n2] = 0; e_ack[n2] = 0; e_ackrd[n2] = 0;
         if (vga_req) begin
            e_en[n1] = 1;
            last_addr = vga_addr;
            e_vv[n2] = 1;
            e_vd[n2] = mdl_rd(vga_addr);
         end else if (cpu_req && idle) begin
            iss = 1;
            free_at = c + 3;
            e_ack[n2] = 1;
            if (!cpu_we) begin
               e_en[n1] = 1;
               last_addr = cpu_addr;
               e_ackrd[n2] = 1;
               e_crd[n2] = mdl_rd(cpu_addr);
            end else if (PROT && cpu_addr[14:11] == 4'b0111) begin
               if (prot_at < 0) prot_at = c + 1;
            end else begin
               e_en[n1] = 1;
               e_we[n1] = 1;
               last_addr = cpu_addr;
               last_din = cpu_wdata;
               mdl_ram[cpu_addr] = cpu_wdata;
               mdl_wr[cpu_addr] = 1;
            end
         end
         e_addr[n1] = last_addr;
         e_din[n1]  = last_din;
         if (iss) wcnt = 0;
         else if (cpu_req && idle && wcnt < SL) wcnt++;
         e_st[n1] = (wcnt >= SL);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cpu_txn(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat,
                          output logic [DW-1:0] rd);
      bit got;
      got = 0; lat = 0; rd = '0;
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge CLK);
         if (cpu_ack) begin
            got = 1;
            rd = cpu_rdata;
         end else begin
            tick();
            lat++;
         end
      end
      chk("txn_ack_seen", got, 1);
      tick();
      cpu_req = 0; cpu_we = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, acks, issues, first;
      bit got;
      logic [DW-1:0] rd;

      repeat (3) tick();
      RST_N = 1;
      tick();

      // Reset in the middle of a CPU read: no ack may appear.
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2010;
      tick();
      @(negedge CLK);
      chk("t1_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'h2010});
      #1;
      RST_N = 0;
      cpu_req = 0;
      tick();
      @(negedge CLK);
      chk("t1_no_ack_rst", cpu_ack, 0);
      chk("t1_rst_mem_en", mem_en, 0);
      tick();
      RST_N = 1;
      tick();
      @(negedge CLK);
      chk("t1_no_ack_after", cpu_ack, 0);
      tick();

      // VGA only, one request every second cycle.
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            vga_req = 1;
            vga_addr = 15'h2000 + 15'(i);
         end
         if (i > 0) begin
            @(negedge CLK);
            chk("t2_vga_rvalid", vga_rvalid, 1);
            chk("t2_vga_rdata", vga_rdata, 64'(16'h2000 + 16'(i - 1)));
         end
         tick();
         vga_req = 0;
         tick();
      end

      // CPU write then read back.
      cpu_txn(1'b1, 15'h2050, 16'h3A5C, lat, rd);
      chk("t3_wr_lat", lat, 2);
      cpu_txn(1'b0, 15'h2050, 16'h0000, lat, rd);
      chk("t3_rd_lat", lat, 2);
      chk("t3_rd_data", rd, 16'h3A5C);

      // Collision: VGA first, CPU in the next slot.
      vga_req = 1; vga_addr = 15'h2004;
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2100;
      tick();
      vga_req = 0;
      @(negedge CLK);
      chk("t4_vga_slot", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'h2004});
      tick();
      @(negedge CLK);
      chk("t4_cpu_slot", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 15'h2100});
      chk("t4_vga_ret", {vga_rvalid, vga_rdata}, {1'b1, 16'h2004});
      tick();
      @(negedge CLK);
      chk("t4_cpu_ack", cpu_ack, 1);
      chk("t4_cpu_rdata", cpu_rdata, 16'h2100);
      tick();
      cpu_req = 0;
      tick();

      // Back-to-back: req held high for 12 cycles.
      acks = 0; issues = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2200;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         acks += int'(cpu_ack);
         issues += int'(mem_en);
         tick();
      end
      cpu_req = 0;
      chk("t5_acks", acks, 4);
      chk("t5_issues", issues, 4);
      tick();

      // Starvation: VGA hogs the port for 40 cycles.
      first = -1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2300;
      for (int k = 0; k < 40; k++) begin
         vga_req = 1;
         vga_addr = 15'h2000 + 15'(k);
         @(negedge CLK);
         if (cpu_starve && first < 0) first = k;
         tick();
      end
      vga_req = 0;
      chk("t6_starve_at", first, 31);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge CLK);
         if (cpu_ack) got = 1;
         tick();
      end
      chk("t6_ack", got, 1);
      cpu_req = 0;
      tick();
      @(negedge CLK);
      chk("t6_starve_clr", cpu_starve, 0);
      tick();

      // Glyph-region write then read back.
      cpu_txn(1'b1, 15'h3800, 16'h1234, lat, rd);
      chk("t7_wr_lat", lat, 2);
      cpu_txn(1'b0, 15'h3800, 16'h0000, lat, rd);
`ifdef VRAM_ARB_VGA_PROTECT_EN
      chk("t7_rd_protected", rd, 16'h3800);
      @(negedge CLK);
      chk("t7_prot_err", prot_err, 1);
`else
      chk("t7_rd_written", rd, 16'h1234);
`endif

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
